// File: rtl/vga_pkg.sv
// Shared constants and types for the sprite blitter and its address generator.
// Screen geometry, sprite buffer layout and the blit FSM state encoding.
package vga_pkg;

    localparam int SCREEN_WIDTH  = 320;
    localparam int SCREEN_HEIGHT = 180;
    localparam int SPRITE_SIZE   = 32;
    localparam int SPRITE_COUNT  = 8;
    localparam int FB_A_WIDTH    = 16;
    localparam int SB_A_WIDTH    = 13;
    localparam int D_WIDTH       = 8;
    localparam int SPR_BITS      = 3;
    localparam int PIX_BITS      = $clog2(SPRITE_SIZE);
    localparam int DRAIN_CYCLES  = 2;

    localparam logic [D_WIDTH-1:0] TRANSPARENT = 8'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } blit_state_e;

endpackage

// File: rtl/blit_addr_gen.sv
// Sprite pixel scanner: raster px/py counters, sprite buffer address,
// frame buffer address and on-screen flag for the current pixel.
module blit_addr_gen
    import vga_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_load,
    input  logic                  i_step,
    input  logic [SPR_BITS-1:0]   i_sprite,
    input  logic [9:0]            i_x,
    input  logic [8:0]            i_y,
    output logic                  o_last,
    output logic [SB_A_WIDTH-1:0] o_sb_addr,
    output logic [FB_A_WIDTH-1:0] o_fb_addr,
    output logic                  o_on_screen
);

    logic [SPR_BITS-1:0] sprite_q, sprite_d;
    logic [9:0]          x_q, x_d;
    logic [8:0]          y_q, y_d;
    logic [PIX_BITS-1:0] px_q, px_d, py_q, py_d;
    logic [10:0]         xs_s;
    logic [9:0]          ys_s;

    // Command latch and raster counters
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sprite_q <= '0;
            x_q      <= '0;
            y_q      <= '0;
            px_q     <= '0;
            py_q     <= '0;
        end else begin
            sprite_q <= sprite_d;
            x_q      <= x_d;
            y_q      <= y_d;
            px_q     <= px_d;
            py_q     <= py_d;
        end
    end

    // Counter next-state: load restarts at pixel 0, step advances px fastest
    always_comb begin
        sprite_d = sprite_q;
        x_d      = x_q;
        y_d      = y_q;
        px_d     = px_q;
        py_d     = py_q;
        if (i_load) begin
            sprite_d = i_sprite;
            x_d      = i_x;
            y_d      = i_y;
            px_d     = '0;
            py_d     = '0;
        end else if (i_step) begin
            px_d = px_q + PIX_BITS'(1);
            if (px_q == {PIX_BITS{1'b1}}) begin
                py_d = py_q + PIX_BITS'(1);
            end else begin
                py_d = py_q;
            end
        end else begin
            px_d = px_q;
        end
    end

    // Widened sums never wrap, so clipping is a plain compare; 320 = 256 + 64
    assign xs_s        = {1'b0, x_q} + {6'd0, px_q};
    assign ys_s        = {1'b0, y_q} + {5'd0, py_q};
    assign o_on_screen = (xs_s < 11'(SCREEN_WIDTH)) && (ys_s < 10'(SCREEN_HEIGHT));
    assign o_fb_addr   = (FB_A_WIDTH'(ys_s) << 8) + (FB_A_WIDTH'(ys_s) << 6) + FB_A_WIDTH'(xs_s);
    assign o_sb_addr   = {sprite_q, py_q, px_q};
    assign o_last      = (px_q == {PIX_BITS{1'b1}}) && (py_q == {PIX_BITS{1'b1}});

endmodule

// File: rtl/sprite_blitter.sv
// Command-driven engine copying one 32x32 sprite into the back frame buffer,
// skipping transparent pixels and clipping at the screen edges.
module sprite_blitter
    import vga_pkg::*;
#(
    parameter int N_SPRITES = SPRITE_COUNT
)
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [SPR_BITS-1:0]   i_sprite,
    input  logic [9:0]            i_x,
    input  logic [8:0]            i_y,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [SB_A_WIDTH-1:0] o_sb_addr,
    input  logic [D_WIDTH-1:0]    i_sb_data,
    output logic [FB_A_WIDTH-1:0] o_fb_addr,
    output logic [D_WIDTH-1:0]    o_fb_data,
    output logic                  o_fb_we
);

    blit_state_e           state_q, state_d;
    logic [1:0]            drain_q, drain_d;
    logic [SPR_BITS:0]     spr_ext_s;
    logic                  bad_s, load_s, run_s, last_s, on_screen_s;
    logic [SB_A_WIDTH-1:0] sb_addr_s, sb_addr_q, sb_addr_d;
    logic [FB_A_WIDTH-1:0] fb_addr_s, fb_a_q, fb_b_q, fb_addr_q, fb_addr_d;
    logic                  vld_a_q, vld_b_q, on_a_q, on_b_q;
    logic [D_WIDTH-1:0]    fb_data_q, fb_data_d;
    logic                  fb_we_q, fb_we_d, busy_q, busy_d, done_q, done_d;

    assign spr_ext_s = {1'b0, i_sprite};
    assign bad_s     = (spr_ext_s >= (SPR_BITS+1)'(N_SPRITES));
    assign run_s     = (state_q == RUN);
    assign load_s    = (state_q == IDLE) && i_start && !bad_s;

    blit_addr_gen u_addr_gen (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_load      (load_s),
        .i_step      (run_s),
        .i_sprite    (i_sprite),
        .i_x         (i_x),
        .i_y         (i_y),
        .o_last      (last_s),
        .o_sb_addr   (sb_addr_s),
        .o_fb_addr   (fb_addr_s),
        .o_on_screen (on_screen_s)
    );

    // State register and drain counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            drain_q <= 2'd0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    // Next-state logic; a bad sprite index skips straight to DONE
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    if (bad_s) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_d = DRAIN;
                    drain_d = 2'd0;
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (drain_q == 2'(DRAIN_CYCLES - 1)) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: write is qualified by the delayed valid/clip bits and the colour key
    always_comb begin
        sb_addr_d = sb_addr_q;
        if (run_s) begin
            sb_addr_d = sb_addr_s;
        end else begin
            sb_addr_d = sb_addr_q;
        end
        fb_addr_d = fb_b_q;
        fb_data_d = i_sb_data;
        fb_we_d   = vld_b_q && on_b_q && (i_sb_data != TRANSPARENT);
        busy_d    = (state_d != IDLE);
        done_d    = (state_q == DONE);
    end

    // Two-stage address/valid delay line matching the sprite buffer read latency
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fb_a_q    <= '0;
            fb_b_q    <= '0;
            vld_a_q   <= 1'b0;
            vld_b_q   <= 1'b0;
            on_a_q    <= 1'b0;
            on_b_q    <= 1'b0;
            sb_addr_q <= '0;
            fb_addr_q <= '0;
            fb_data_q <= '0;
            fb_we_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            fb_a_q    <= fb_addr_s;
            fb_b_q    <= fb_a_q;
            vld_a_q   <= run_s;
            vld_b_q   <= vld_a_q;
            on_a_q    <= on_screen_s;
            on_b_q    <= on_a_q;
            sb_addr_q <= sb_addr_d;
            fb_addr_q <= fb_addr_d;
            fb_data_q <= fb_data_d;
            fb_we_q   <= fb_we_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_sb_addr = sb_addr_q;
    assign o_fb_addr = fb_addr_q;
    assign o_fb_data = fb_data_q;
    assign o_fb_we   = fb_we_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter: expected frame-buffer writes are queued
// when a blit is issued and popped as the DUT writes.
module tb_sprite_blitter;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, start4;
    logic [2:0]  sprite;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        busy, done, fb_we;
    logic [12:0] sb_addr;
    logic [7:0]  sb_data;
    logic [15:0] fb_addr;
    logic [7:0]  fb_data;
    logic        busy4, done4, fb_we4;
    logic [12:0] sb_addr4;
    logic [7:0]  sb_data4;
    logic [15:0] fb_addr4;
    logic [7:0]  fb_data4;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int zero_cnt = 0;
    int we4_cnt = 0;
    logic [7:0] sprite_mem [0:8191];
    wr_t exp_q[$];
    wr_t exp_m;

    always #5 clk = ~clk;

    sprite_blitter dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_sprite(sprite),
        .i_x(x), .i_y(y), .o_busy(busy), .o_done(done), .o_sb_addr(sb_addr),
        .i_sb_data(sb_data), .o_fb_addr(fb_addr), .o_fb_data(fb_data), .o_fb_we(fb_we)
    );

    sprite_blitter #(.N_SPRITES(4)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start4), .i_sprite(sprite),
        .i_x(x), .i_y(y), .o_busy(busy4), .o_done(done4), .o_sb_addr(sb_addr4),
        .i_sb_data(sb_data4), .o_fb_addr(fb_addr4), .o_fb_data(fb_data4), .o_fb_we(fb_we4)
    );

    // Sprite buffer: registered SRAM, data one cycle after the address
    always @(posedge clk) sb_data <= sprite_mem[sb_addr];

    // Write monitor: every write must match the head of the scoreboard
    always @(negedge clk) begin
        if (fb_we4 === 1'b1) we4_cnt++;
        if (fb_we === 1'b1) begin
            wr_cnt++;
            if (fb_data == 8'h00) zero_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr %0d data %0h, expected no write", fb_addr, fb_data);
            end else begin
                exp_m = exp_q.pop_front();
                if (fb_addr !== exp_m.addr || fb_data !== exp_m.data) begin
                    errors++;
                    $display("FAIL fb_write: got addr %0d data %0h, expected addr %0d data %0h",
                             fb_addr, fb_data, exp_m.addr, exp_m.data);
                end
            end
            checks++;
            if (fb_addr >= 16'd57600) begin
                errors++;
                $display("FAIL fb_range: got addr %0d, expected < 57600", fb_addr);
            end
        end
    end

    task automatic run_blit(input int s, input int xx, input int yy, input int pulse_at,
                            output int done_at, output int extra_dones, output logic busy_at_done);
        int n;
        int xs, ys;
        logic [7:0] d;
        wr_t w;
        @(negedge clk);
        wr_cnt = 0;
        zero_cnt = 0;
        for (int py = 0; py < 32; py++) begin
            for (int px = 0; px < 32; px++) begin
                xs = xx + px;
                ys = yy + py;
                d  = sprite_mem[s * 1024 + py * 32 + px];
                if (d != 8'h00 && xs < 320 && ys < 180) begin
                    w.addr = 16'(ys * 320 + xs);
                    w.data = d;
                    exp_q.push_back(w);
                end
            end
        end
        sprite = 3'(s);
        x = 10'(xx);
        y = 9'(yy);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        done_at = -1;
        extra_dones = 0;
        busy_at_done = 1'bx;
        while (done_at < 0 && n < 2000) begin
            @(posedge clk); #1;
            n++;
            start = (n == pulse_at);
            if (n == pulse_at) begin
                sprite = 3'd2;
                x = 10'd5;
                y = 9'd3;
            end
            if (done === 1'b1) begin
                done_at = n;
                busy_at_done = busy;
            end
        end
        start = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done !== 1'b0) extra_dones++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done: got %b, expected 0", done); end
        checks++; if (fb_we !== 1'b0)    begin errors++; $display("FAIL reset_fb_we: got %b, expected 0", fb_we); end
        checks++; if (sb_addr !== 13'd0) begin errors++; $display("FAIL reset_sb_addr: got %0d, expected 0", sb_addr); end
        checks++; if (fb_addr !== 16'd0) begin errors++; $display("FAIL reset_fb_addr: got %0d, expected 0", fb_addr); end
        checks++; if (fb_data !== 8'd0)  begin errors++; $display("FAIL reset_fb_data: got %0h, expected 0", fb_data); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_full_copy();
        int d_at, extra;
        logic b;
        run_blit(0, 144, 148, 0, d_at, extra, b);
        checks++; if (d_at !== 1027)     begin errors++; $display("FAIL full_done_cycle: got %0d, expected 1027", d_at); end
        checks++; if (b !== 1'b0)        begin errors++; $display("FAIL full_busy_after: got %b, expected 0", b); end
        checks++; if (extra !== 0)       begin errors++; $display("FAIL full_done_pulse: got %0d extra, expected 0", extra); end
        checks++; if (wr_cnt !== 1024)   begin errors++; $display("FAIL full_writes: got %0d, expected 1024", wr_cnt); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL full_missing: got %0d left, expected 0", exp_q.size()); end
    endtask

    task automatic test_transparency();
        int d_at, extra;
        logic b;
        run_blit(7, 10, 20, 0, d_at, extra, b);
        checks++; if (d_at !== 1027)     begin errors++; $display("FAIL trans_done_cycle: got %0d, expected 1027", d_at); end
        checks++; if (wr_cnt !== 512)    begin errors++; $display("FAIL trans_writes: got %0d, expected 512", wr_cnt); end
        checks++; if (zero_cnt !== 0)    begin errors++; $display("FAIL trans_zero_data: got %0d, expected 0", zero_cnt); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL trans_missing: got %0d left, expected 0", exp_q.size()); end
    endtask

    task automatic test_clipping();
        int d_at, extra;
        logic b;
        run_blit(0, 300, 170, 0, d_at, extra, b);
        checks++; if (d_at !== 1027)     begin errors++; $display("FAIL clip_done_cycle: got %0d, expected 1027", d_at); end
        checks++; if (wr_cnt !== 200)    begin errors++; $display("FAIL clip_writes: got %0d, expected 200", wr_cnt); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL clip_missing: got %0d left, expected 0", exp_q.size()); end
    endtask

    task automatic test_busy_ignore();
        int d_at, extra;
        logic b;
        run_blit(0, 0, 0, 100, d_at, extra, b);
        checks++; if (d_at !== 1027)     begin errors++; $display("FAIL ignore_done_cycle: got %0d, expected 1027", d_at); end
        checks++; if (extra !== 0)       begin errors++; $display("FAIL ignore_done_pulse: got %0d extra, expected 0", extra); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL ignore_busy: got %b, expected 0", busy); end
        checks++; if (wr_cnt !== 1024)   begin errors++; $display("FAIL ignore_writes: got %0d, expected 1024", wr_cnt); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ignore_missing: got %0d left, expected 0", exp_q.size()); end
    endtask

    task automatic test_bad_index();
        int n;
        @(negedge clk);
        we4_cnt = 0;
        sprite = 3'd5;
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        checks++; if (done4 !== 1'b0) begin errors++; $display("FAIL bad_done_e0: got %b, expected 0", done4); end
        @(posedge clk); #1;
        checks++; if (done4 !== 1'b1) begin errors++; $display("FAIL bad_done_e1: got %b, expected 1", done4); end
        checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL bad_busy_e1: got %b, expected 0", busy4); end
        @(posedge clk); #1;
        checks++; if (done4 !== 1'b0)      begin errors++; $display("FAIL bad_done_e2: got %b, expected 0", done4); end
        checks++; if (sb_addr4 !== 13'd0)  begin errors++; $display("FAIL bad_no_read: got %0d, expected 0", sb_addr4); end
        checks++; if (we4_cnt !== 0)       begin errors++; $display("FAIL bad_no_write: got %0d, expected 0", we4_cnt); end
        // A legal index on the same instance must still run a full blit
        @(negedge clk);
        sprite = 3'd3;
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy4 !== 1'b1) begin errors++; $display("FAIL good4_busy: got %b, expected 1", busy4); end
        n = 0;
        while (busy4 === 1'b1 && n < 1200) begin @(posedge clk); #1; n++; end
        checks++; if (n !== 1026) begin errors++; $display("FAIL good4_busy_len: got %0d, expected 1026", n); end
    endtask

    task automatic test_reset_mid_blit();
        int d_at, extra;
        logic b;
        wr_t w;
        @(negedge clk);
        wr_cnt = 0;
        for (int k = 0; k < 1024; k++) begin
            w.addr = 16'((k / 32) * 320 + (k % 32));
            w.data = 8'h05;
            exp_q.push_back(w);
        end
        sprite = 3'd0;
        x = 10'd0;
        y = 9'd0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (500) @(posedge clk);
        #1;
        checks++; if (fb_we !== 1'b1) begin errors++; $display("FAIL rst_pre_we: got %b, expected 1", fb_we); end
        rst_n = 1'b0;
        #1;
        checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL rst_async_we: got %b, expected 0", fb_we); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL rst_async_busy: got %b, expected 0", busy); end
        checks++; if (done !== 1'b0)  begin errors++; $display("FAIL rst_async_done: got %b, expected 0", done); end
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        run_blit(0, 50, 60, 0, d_at, extra, b);
        checks++; if (d_at !== 1027)     begin errors++; $display("FAIL rst_fresh_done: got %0d, expected 1027", d_at); end
        checks++; if (wr_cnt !== 1024)   begin errors++; $display("FAIL rst_fresh_writes: got %0d, expected 1024", wr_cnt); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rst_fresh_missing: got %0d left, expected 0", exp_q.size()); end
    endtask

    initial begin
        start = 1'b0;
        start4 = 1'b0;
        sprite = 3'd0;
        x = 10'd0;
        y = 9'd0;
        sb_data4 = 8'h00;
        for (int i = 0; i < 8192; i++) sprite_mem[i] = 8'h00;
        for (int i = 0; i < 1024; i++) sprite_mem[i] = 8'h05;
        for (int py = 0; py < 32; py++) begin
            for (int px = 0; px < 32; px++) begin
                sprite_mem[7 * 1024 + py * 32 + px] = ((px ^ py) & 1) != 0 ? 8'h00 : 8'(8'h80 | (py * 4 + px));
            end
        end
        test_reset();
        test_full_copy();
        test_transparency();
        test_clipping();
        test_busy_ignore();
        test_bad_index();
        test_reset_mid_blit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
